// File: rtl/obi_mem_responder.sv
// Single-port on-chip memory behind an OBI responder port.
// Fixed-latency in-order responses, bounded outstanding count, stall-throttled grant.
package core_pkg;
   localparam int unsigned ADDR_WIDTH = 32;
   localparam int unsigned DATA_WIDTH = 32;
endpackage

module obi_mem_responder #(
   parameter int unsigned           ADDR_WIDTH     = core_pkg::ADDR_WIDTH,
   parameter int unsigned           DATA_WIDTH     = core_pkg::DATA_WIDTH,
   parameter int unsigned           Depth          = 1024,
   parameter logic [ADDR_WIDTH-1:0] BaseAddress    = '0,
   parameter int unsigned           Latency        = 1,
   parameter int unsigned           MaxOutstanding = 2
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    stall_i,
   input  logic                    req_i,
   output logic                    gnt_o,
   input  logic [ADDR_WIDTH-1:0]   addr_i,
   input  logic                    we_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   input  logic [DATA_WIDTH/8-1:0] be_i,
   output logic                    rvalid_o,
   output logic [DATA_WIDTH-1:0]   rdata_o,
   output logic                    err_o
);

   localparam int unsigned     BE_W      = DATA_WIDTH / 8;
   localparam int unsigned     OFF_BITS  = $clog2(BE_W);
   localparam int unsigned     IDX_W     = $clog2(Depth);
   localparam int unsigned     CNT_W     = $clog2(MaxOutstanding + 1);
   localparam longint unsigned MEM_BYTES = longint'(Depth) * longint'(BE_W);

   if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
      $fatal(1, "obi_mem_responder: DATA_WIDTH must be 32 or 64");
   end
   if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
      $fatal(1, "obi_mem_responder: Depth must be a power of two >= 2");
   end
   if ((BaseAddress & ADDR_WIDTH'(BE_W - 1)) != '0) begin : g_bad_base
      $fatal(1, "obi_mem_responder: BaseAddress must be word-aligned");
   end
   if (Latency < 1 || Latency > 8) begin : g_bad_latency
      $fatal(1, "obi_mem_responder: Latency must be in 1..8");
   end
   if (MaxOutstanding < 1 || MaxOutstanding > Latency + 1) begin : g_bad_outstanding
      $fatal(1, "obi_mem_responder: MaxOutstanding must be in 1..Latency+1");
   end

   logic [DATA_WIDTH-1:0] mem [Depth];

   logic [ADDR_WIDTH-1:0] offset;
   logic                  in_range;
   logic [IDX_W-1:0]      index;
   logic                  accept;
   logic [CNT_W-1:0]      cnt;
   logic [DATA_WIDTH-1:0] entry_rdata;
   logic                  entry_err;

   logic [Latency-1:0]    pipe_valid;
   logic [Latency-1:0]    pipe_err;
   logic [DATA_WIDTH-1:0] pipe_rdata [Latency];

   // Address decode: byte offset bits are dropped, no misalignment error
   assign offset   = addr_i - BaseAddress;
   assign in_range = 64'(offset) < MEM_BYTES;
   assign index    = IDX_W'(offset >> OFF_BITS);

   // A retiring response frees its slot in the same cycle
   assign gnt_o  = !rst_i && !stall_i && ((cnt < CNT_W'(MaxOutstanding)) || rvalid_o);
   assign accept = req_i && gnt_o;

   // Writes commit at the accept edge, so a following read sees the new data
   always_ff @(posedge clk_i) begin
      if (accept && in_range && we_i) begin
         for (int k = 0; k < BE_W; k++) begin
            if (be_i[k]) mem[index][k*8 +: 8] <= wdata_i[k*8 +: 8];
         end
      end
   end

   always_comb begin
      entry_rdata = '0;
      entry_err   = 1'b0;
      if (!in_range) begin
         entry_err = 1'b1;
      end else if (!we_i) begin
         entry_rdata = mem[index];
      end
   end

   // Response shift pipeline; empty stages carry all-zero payload
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pipe_valid <= '0;
         pipe_err   <= '0;
         for (int i = 0; i < Latency; i++) pipe_rdata[i] <= '0;
      end else begin
         pipe_valid[0] <= accept;
         pipe_err[0]   <= accept && entry_err;
         pipe_rdata[0] <= accept ? entry_rdata : '0;
         for (int i = 1; i < Latency; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_err[i]   <= pipe_err[i-1];
            pipe_rdata[i] <= pipe_rdata[i-1];
         end
      end
   end

   assign rvalid_o = pipe_valid[Latency-1];
   assign err_o    = pipe_err[Latency-1];
   assign rdata_o  = pipe_rdata[Latency-1];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt <= '0;
      end else if (accept && !rvalid_o) begin
         cnt <= cnt + CNT_W'(1);
      end else if (!accept && rvalid_o) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_obi_mem_responder.sv
// Bench for obi_mem_responder: two instances (Latency 1 and 3) checked against a
// transaction-level model (word array plus a queue of due responses).
module tb_obi_mem_responder;

   logic        clk   = 1'b0;
   logic        rst   = 1'b1;
   logic        stall = 1'b0;
   logic        req1  = 1'b0;
   logic        req3  = 1'b0;
   logic        we    = 1'b0;
   logic [31:0] addr  = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  be    = '0;
   logic        gnt1, gnt3, rv1, rv3, er1, er3;
   logic [31:0] rd1, rd3;

   always #5 clk = ~clk;

   obi_mem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .Depth(256),
      .BaseAddress(32'h1000), .Latency(1), .MaxOutstanding(2)) dut1 (
      .clk_i(clk), .rst_i(rst), .stall_i(stall), .req_i(req1), .gnt_o(gnt1),
      .addr_i(addr), .we_i(we), .wdata_i(wdata), .be_i(be),
      .rvalid_o(rv1), .rdata_o(rd1), .err_o(er1));

   obi_mem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .Depth(256),
      .BaseAddress(32'h1000), .Latency(3), .MaxOutstanding(2)) dut3 (
      .clk_i(clk), .rst_i(rst), .stall_i(stall), .req_i(req3), .gnt_o(gnt3),
      .addr_i(addr), .we_i(we), .wdata_i(wdata), .be_i(be),
      .rvalid_o(rv3), .rdata_o(rd3), .err_o(er3));

   typedef struct {
      int          due;
      logic [31:0] rdata;
      logic        err;
   } resp_t;

   resp_t       q[$];
   bit          retiring = 1'b0;
   int          stepn    = 0;
   int          checks   = 0;
   int          errors   = 0;
   logic [31:0] mm [2][256];

   // Memory semantics: 256 words from 0x1000, byte-enabled writes, anything else errors
   function automatic void model_accept(input int d, input bit w, input logic [31:0] a,
                                        input logic [31:0] wd, input logic [3:0] b,
                                        output logic [31:0] rd, output logic e);
      logic [31:0] off;
      logic [7:0]  idx;
      off = a - 32'h1000;
      idx = off[9:2];
      rd  = '0;
      e   = 1'b0;
      if (off >= 32'd1024) begin
         e = 1'b1;
      end else if (w) begin
         for (int k = 0; k < 4; k++) if (b[k]) mm[d][idx][k*8 +: 8] = wd[k*8 +: 8];
      end else begin
         rd = mm[d][idx];
      end
   endfunction

   // One clock of stimulus on instance d (0: Latency 1, 1: Latency 3); returns observed and modelled values
   task automatic step(input int d, input bit r, input bit s, input bit rq, input bit w,
                       input logic [31:0] a, input logic [31:0] wd, input logic [3:0] b,
                       output logic go, output logic ge, output logic [33:0] ro, output logic [33:0] re);
      logic [31:0] rd;
      logic        e;
      int          lat;
      lat = (d == 0) ? 1 : 3;
      @(negedge clk);
      rst = r; stall = s; we = w; addr = a; wdata = wd; be = b;
      req1 = (d == 0) && rq;
      req3 = (d == 1) && rq;
      if (r) begin
         q.delete();
         retiring = 1'b0;
      end
      #1;
      go = (d == 0) ? gnt1 : gnt3;
      ge = !r && !s && (((q.size() + int'(retiring)) < 2) || retiring);
      if (rq && go === 1'b1) begin
         model_accept(d, w, a, wd, b, rd, e);
         q.push_back('{stepn + lat - 1, rd, e});
      end
      @(posedge clk);
      #1;
      ro = (d == 0) ? {rv1, er1, rd1} : {rv3, er3, rd3};
      re = '0;
      retiring = 1'b0;
      if (q.size() != 0 && q[0].due == stepn) begin
         re = {1'b1, q[0].err, q[0].rdata};
         void'(q.pop_front());
         retiring = 1'b1;
      end
      stepn++;
   endtask

   task automatic test_reset();
      logic go, ge;
      logic [33:0] ro, re;
      for (int i = 0; i < 4; i++) begin
         step(0, i < 3, 1'b0, 1'b1, 1'b1, 32'h1004, 32'hDEADBEEF, 4'hF, go, ge, ro, re);
         checks++;
         if (go !== ge) begin errors++; $display("FAIL reset_gnt step %0d: got %b want %b", i, go, ge); end
         checks++;
         if (ro !== re) begin errors++; $display("FAIL reset_resp step %0d: got %h want %h", i, ro, re); end
      end
   endtask

   task automatic test_write_read();
      logic go, ge;
      logic [33:0] ro, re;
      bit          tw [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [31:0] ta [5] = '{32'h1004, 32'h0, 32'h1008, 32'h1008, 32'h1004};
      logic [31:0] td [5] = '{32'h0, 32'h0, 32'hCAFEF00D, 32'h0, 32'h0};
      bit          tr [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 5; i++) begin
         step(0, 1'b0, 1'b0, tr[i], tw[i], ta[i], td[i], 4'hF, go, ge, ro, re);
         checks++;
         if (go !== ge) begin errors++; $display("FAIL wr_rd_gnt step %0d: got %b want %b", i, go, ge); end
         checks++;
         if (ro !== re) begin errors++; $display("FAIL wr_rd_resp step %0d: got %h want %h", i, ro, re); end
         if (i == 0) begin
            checks++;
            if (ro !== {2'b10, 32'hDEADBEEF}) begin errors++; $display("FAIL wr_rd_value: got %h want %h", ro, {2'b10, 32'hDEADBEEF}); end
         end
      end
   endtask

   task automatic test_partial();
      logic go, ge;
      logic [33:0] ro, re;
      step(0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1004, 32'h0000AA00, 4'b0010, go, ge, ro, re);
      checks++;
      if (ro !== re) begin errors++; $display("FAIL partial_wr_resp: got %h want %h", ro, re); end
      step(0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1004, 32'h0, 4'h0, go, ge, ro, re);
      checks++;
      if (go !== ge) begin errors++; $display("FAIL partial_gnt: got %b want %b", go, ge); end
      checks++;
      if (ro !== {2'b10, 32'hDEADAAEF}) begin errors++; $display("FAIL partial_value: got %h want %h", ro, {2'b10, 32'hDEADAAEF}); end
   endtask

   task automatic test_out_of_range();
      logic go, ge;
      logic [33:0] ro, re;
      bit          tw [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [31:0] ta [5] = '{32'h1000, 32'h0FFC, 32'h1400, 32'h1400, 32'h1000};
      logic [31:0] td [5] = '{32'h11223344, 32'h0, 32'h0, 32'h12345678, 32'h0};
      logic [33:0] tx [5] = '{34'h0, {2'b11, 32'h0}, {2'b11, 32'h0}, {2'b11, 32'h0}, {2'b10, 32'h11223344}};
      for (int i = 0; i < 5; i++) begin
         step(0, 1'b0, 1'b0, 1'b1, tw[i], ta[i], td[i], 4'hF, go, ge, ro, re);
         checks++;
         if (ro !== re) begin errors++; $display("FAIL oor_resp step %0d: got %h want %h", i, ro, re); end
         if (i != 0) begin
            checks++;
            if (ro !== tx[i]) begin errors++; $display("FAIL oor_value step %0d: got %h want %h", i, ro, tx[i]); end
         end
      end
   endtask

   task automatic test_outstanding();
      logic go, ge;
      logic [33:0] ro, re;
      logic [31:0] data [4];
      int sent, got, n;
      for (int k = 0; k < 4; k++) data[k] = $urandom;
      sent = 0; got = 0; n = 0;
      while ((sent < 8 || q.size() != 0) && n < 40) begin
         step(1, 1'b0, 1'b0, sent < 8, sent < 4, 32'h1000 + 32'((sent % 4) * 4), data[sent % 4],
              4'hF, go, ge, ro, re);
         checks++;
         if (go !== ge) begin errors++; $display("FAIL outst_gnt step %0d: got %b want %b", n, go, ge); end
         checks++;
         if (ro !== re) begin errors++; $display("FAIL outst_resp step %0d: got %h want %h", n, ro, re); end
         if (sent < 8 && go === 1'b1) sent++;
         if (ro[33] === 1'b1) got++;
         n++;
      end
      checks++;
      if (got != 8 || n >= 40) begin errors++; $display("FAIL outst_count: got %0d responses in %0d cycles want 8", got, n); end
   endtask

   task automatic test_stall();
      logic go, ge;
      logic [33:0] ro, re;
      int nrv;
      nrv = 0;
      step(1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1004, 32'h0, 4'hF, go, ge, ro, re);
      checks++;
      if (go !== 1'b1) begin errors++; $display("FAIL stall_first_gnt: got %b want 1", go); end
      for (int i = 0; i < 8; i++) begin
         step(1, 1'b0, i < 5, i < 5, 1'b0, 32'h1008, 32'h0, 4'hF, go, ge, ro, re);
         checks++;
         if (go !== ge) begin errors++; $display("FAIL stall_gnt step %0d: got %b want %b", i, go, ge); end
         checks++;
         if (ro !== re) begin errors++; $display("FAIL stall_resp step %0d: got %h want %h", i, ro, re); end
         if (ro[33] === 1'b1) nrv++;
      end
      checks++;
      if (nrv != 1) begin errors++; $display("FAIL stall_inflight: got %0d responses want 1", nrv); end
   endtask

   task automatic test_mid_reset();
      logic go, ge;
      logic [33:0] ro, re;
      int nrv;
      nrv = 0;
      for (int i = 0; i < 2; i++) begin
         step(1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1000 + 32'(i * 4), 32'h0, 4'hF, go, ge, ro, re);
         checks++;
         if (go !== 1'b1) begin errors++; $display("FAIL mrst_accept %0d: got %b want 1", i, go); end
      end
      for (int i = 0; i < 8; i++) begin
         step(1, i < 2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, go, ge, ro, re);
         checks++;
         if (go !== ge) begin errors++; $display("FAIL mrst_gnt step %0d: got %b want %b", i, go, ge); end
         if (ro[33] !== 1'b0) nrv++;
      end
      checks++;
      if (nrv != 0) begin errors++; $display("FAIL mrst_no_rvalid: got %0d responses want 0", nrv); end
      checks++;
      if (dut3.cnt !== '0) begin errors++; $display("FAIL mrst_cnt: got %0d want 0", dut3.cnt); end
   endtask

   task automatic test_random(input int d);
      logic go, ge;
      logic [33:0] ro, re;
      logic [31:0] a;
      int n, sel;
      for (int k = 0; k < 16; k++) begin
         n = 0;
         do begin
            step(d, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1000 + 32'(k * 4), $urandom, 4'hF, go, ge, ro, re);
            checks++;
            if (ro !== re) begin errors++; $display("FAIL rnd%0d_init_resp word %0d: got %h want %h", d, k, ro, re); end
            n++;
         end while (go !== 1'b1 && n < 10);
      end
      for (int i = 0; i < 80; i++) begin
         sel = int'($urandom_range(0, 9));
         if (sel < 8)       a = 32'h1000 + 32'($urandom_range(0, 63));
         else if (sel == 8) a = 32'h1400 + 32'($urandom_range(0, 255));
         else               a = 32'h0FF0 + 32'($urandom_range(0, 15));
         step(d, 1'b0, ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
              a, $urandom, 4'($urandom_range(0, 15)), go, ge, ro, re);
         checks++;
         if (go !== ge) begin errors++; $display("FAIL rnd%0d_gnt step %0d: got %b want %b", d, i, go, ge); end
         checks++;
         if (ro !== re) begin errors++; $display("FAIL rnd%0d_resp step %0d: got %h want %h", d, i, ro, re); end
      end
      n = 0;
      while (q.size() != 0 && n < 10) begin
         step(d, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, go, ge, ro, re);
         checks++;
         if (ro !== re) begin errors++; $display("FAIL rnd%0d_drain step %0d: got %h want %h", d, n, ro, re); end
         n++;
      end
      checks++;
      if (q.size() != 0) begin errors++; $display("FAIL rnd%0d_drained: got %0d pending want 0", d, q.size()); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_partial();
      test_out_of_range();
      test_outstanding();
      test_stall();
      test_mid_reset();
      test_random(0);
      test_random(1);
      @(negedge clk);
      req1 = 1'b0;
      req3 = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
